// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory request/response channel.
//   - FSM state encoding used by the responder
//   - WORD_BYTES: bytes per doubleword access
//   - OP_LOAD / OP_STORE: RV64 major opcodes, so decoders and monitors
//     agree on which instruction class maps to which request type
package mem_if_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  localparam int WORD_BYTES = 8;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/dmem_array.sv
// Doubleword RAM behind the responder.
// The write is synchronous; the read is a combinational view of the indexed
// word, which the responder captures on the same edge as the access.
// The array is deliberately not reset, so benches can preload `memory`.
// Ports:
//   clk      clock
//   i_we     write enable for this edge
//   i_idx    word index
//   i_wdata  write data
//   o_rdata  word currently at i_idx
module dmem_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [8*WORD_BYTES-1:0] i_wdata,
  output logic [8*WORD_BYTES-1:0] o_rdata
);

  logic [8*WORD_BYTES-1:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) memory[i_idx] <= i_wdata;
  end

  assign o_rdata = memory[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the CPU's load/store port.
// Accepts one request at a time, waits LATENCY cycles, performs a single
// doubleword access, and holds the response until the CPU takes it.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   req_valid / req_ready    request handshake
//   req_write, req_addr,     store flag, byte address, store data
//   req_wdata
//   resp_valid / resp_ready  response handshake
//   resp_rdata, resp_err     load data (0 for stores/errors), error flag
//   busy                     a request is in flight or awaiting handshake
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(WORD_BYTES);
  // Countdown seeded so the access lands LATENCY-1 edges after acceptance.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;
  logic              r_err;

  logic              w_accept, w_access;
  logic              w_acc_write;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [63:0]       w_acc_wdata;
  logic              w_err, w_we;
  logic [IDX_W-1:0]  w_idx;
  logic [63:0]       w_rdata;

  assign w_accept = req_valid && (r_state == IDLE);

  // With LATENCY==1 the access happens on the acceptance edge, so the live
  // request fields are used; otherwise the latched copy is.
  assign w_access    = (LATENCY == 1) ? w_accept : ((r_state == WAIT) && (r_cnt == 4'd0));
  assign w_acc_write = (r_state == IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

  assign w_idx = w_acc_addr[OFF_W+IDX_W-1:OFF_W];
  // Misaligned, or any address bit above the word index set.
  assign w_err = (|w_acc_addr[OFF_W-1:0]) || (|w_acc_addr[ADDR_W-1:OFF_W+IDX_W]);
  // reset_n gates the write so a clock edge during reset can never commit.
  assign w_we  = w_access && w_acc_write && !w_err && reset_n;

  dmem_array #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req_valid) w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (r_cnt == 4'd0) w_next = RESP;
      RESP: if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP);
    busy       = (r_state != IDLE);
  end

  // Request latch, countdown and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_acc_write) ? 64'd0 : w_rdata;
      end else if ((r_state == RESP) && resp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= 64'd0;
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the sequential CPU's data port: accepts load/store requests over a valid/ready channel, waits a programmable latency, performs a 64-bit doubleword access, and returns a response.
- Replaces the single-cycle combinational data memory so the CPU and benches can exercise multi-cycle memory.
- The testbench can still preload and inspect the `memory` array hierarchically.

Parameters:
- DEPTH, 256, number of 64-bit words in the array (power of two).
- LATENCY, 2, cycles from request acceptance to `resp_valid` rising (legal range 1..15).
- ADDR_W, 64, width of the byte address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store (sd), 0 = load (ld).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  64  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  CPU accepts the response.
- resp_rdata  output  64  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert by design intent): state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, req_ready=1 on the first cycle after release. The memory array is not reset.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance is req_valid && req_ready at a rising edge. On acceptance, latch write flag, address and wdata.
  - If LATENCY==1, perform the access at that edge and go to RESP. Otherwise load counter=LATENCY-2 and go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter==0, perform the access at this edge and go to RESP; else decrement the counter.
- Access rules:
  - Word index is addr[3+log2(DEPTH)-1:3].
  - Error if addr[2:0]!=0 (misaligned), or if any bit above the index is set (out of range).
  - On error: no memory write, resp_err=1, resp_rdata=0.
  - Store without error: memory[idx]<=wdata, resp_rdata=0.
  - Load without error: resp_rdata<=memory[idx].
- Latency: with acceptance at edge N, the access happens at edge N+LATENCY-1, so resp_valid is high in the cycle after that edge (LATENCY cycles after acceptance).
- RESP:
  - resp_valid=1. resp_rdata and resp_err stay stable until the handshake.
  - On resp_ready at an edge: clear resp_valid/resp_err/resp_rdata and go to IDLE. req_ready rises the cycle after that; there is no same-cycle turnaround.
  - Back-pressure holds RESP indefinitely.
- req_valid while not ready is ignored. Request fields need only be stable at the acceptance edge.
- Reset mid-operation returns to IDLE immediately and discards the pending request.
  - A store whose access edge has not yet occurred is never written.
  - A completed store remains in memory.
- Read-after-write: a load issued after a store's response sees the new data.
- Only one request is outstanding at a time.

Decomposition:
- Shared package `mem_if_pkg`:
  - state encoding localparams: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - WORD_BYTES=8.
  - opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011, for shared decode and monitors.
- Natural sub-module: `dmem_array`, a synchronous-write, read-at-access-edge 64-bit RAM holding the `memory` array. The FSM, counter and error check stay in the top.

Test Plan:
- Store 0x15 to addr 0x10 (LATENCY=2), then load addr 0x10 -> store response resp_err=0, resp_rdata=0; load response resp_rdata=0x15; memory[2]=0x15; resp_valid rises exactly 2 cycles after each acceptance.
- LATENCY=1 and LATENCY=5 builds, single load of a preloaded memory[0]=0xDEADBEEF -> resp_valid 1 and 5 cycles after acceptance respectively; busy high from acceptance until the response handshake.
- Store 0xAA to misaligned addr 0x0C, then to addr 8*DEPTH -> both return resp_err=1, resp_rdata=0; memory unchanged (memory[1] keeps its preload).
- Hold resp_ready=0 for 6 cycles in RESP while driving req_valid=1 -> resp_valid/resp_rdata stable; req_ready=0; no second acceptance. After resp_ready=1, req_ready returns one cycle later.
- Assert reset_n=0 in WAIT during a store of 0x77 to addr 0x18 (LATENCY=4) -> outputs return to reset values asynchronously; memory[3] unchanged; the next request after release completes normally.
- Back-to-back loads of x1=10, x2=11 stored at addrs 0x0/0x8 -> responses 10 then 11, in order.
